// File: rtl/queue_ticket_issuer_if.sv
// Customer-side bus of the ticket issuer: button/caller inputs and ticket/queue status outputs.
// ticket_valid qualifies ticket_no; the only back-pressure is print_ack when TICKET_PRINT_ACK_EN is defined.
interface queue_ticket_issuer_if #(
  parameter int NUM_W  = 4,
  parameter int WAIT_W = 4
);
  logic              take_btn;
  logic              serve;
  logic              skip;
  logic              print_ack;
  logic [NUM_W-1:0]  ticket_no;
  logic              ticket_valid;
  logic              rejected;
  logic [WAIT_W-1:0] waiting;
  logic              full;

  modport master (
    output take_btn, serve, skip, print_ack,
    input  ticket_no, ticket_valid, rejected, waiting, full
  );

  modport slave (
    input  take_btn, serve, skip, print_ack,
    output ticket_no, ticket_valid, rejected, waiting, full
  );
endinterface

// File: rtl/queue_ticket_issuer.sv
// Queue ticket issuer: hands out sequential numbers on a button press and counts waiting customers.
// Optional macro TICKET_PRINT_ACK_EN holds each ticket until the printer acknowledges it.
module queue_ticket_issuer #(
  parameter  int NUM_W       = 4,
  parameter  int QUEUE_DEPTH = 15,
  parameter  int START_NO    = 1,
  localparam int WAIT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  queue_ticket_issuer_if.slave bus,
  output logic [1:0]          state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam logic [NUM_W-1:0] START_V = NUM_W'(START_NO);
  localparam logic [NUM_W-1:0] RST_NO  = NUM_W'(START_NO - 1);

  state_e            state_q, state_d;
  logic [NUM_W-1:0]  ticket_no_q, ticket_no_d;
  logic [NUM_W-1:0]  next_no_q, next_no_d;
  logic              valid_q, valid_d;
  logic              rej_q, rej_d;
  logic [WAIT_W-1:0] waiting_q, waiting_d;
  logic              take_q;
  logic              take_ev;
  logic              full;
  logic              inc;
  logic [1:0]        dec;
  logic [1:0]        dec_eff;

  assign take_ev = bus.take_btn & ~take_q;
  assign full    = (waiting_q == WAIT_W'(QUEUE_DEPTH));
  assign dec     = {1'b0, bus.serve} + {1'b0, bus.skip};

`ifndef TICKET_PRINT_ACK_EN
  logic unused_print_ack;
  assign unused_print_ack = bus.print_ack;
`endif

  always_comb begin
    state_d     = state_q;
    ticket_no_d = ticket_no_q;
    next_no_d   = next_no_q;
    valid_d     = valid_q;
    rej_d       = 1'b0;
    inc         = 1'b0;
    case (state_q)
`ifdef TICKET_PRINT_ACK_EN
      // Ticket stays presented until the printer takes it; presses meanwhile are dropped.
      ISSUE, WAIT_ACK: begin
        if (bus.print_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_ACK;
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
        if (take_ev) begin
          if (!full) begin
            ticket_no_d = next_no_q;
            next_no_d   = next_no_q + NUM_W'(1);
            valid_d     = 1'b1;
            inc         = 1'b1;
            state_d     = ISSUE;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Serve/skip never take the count below zero; a new ticket is added after the clamp.
  always_comb begin
    dec_eff = dec;
    if (waiting_q == '0) begin
      dec_eff = 2'd0;
    end else if (waiting_q == WAIT_W'(1) && dec == 2'd2) begin
      dec_eff = 2'd1;
    end
    waiting_d = waiting_q - WAIT_W'(dec_eff) + WAIT_W'(inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ticket_no_q <= RST_NO;
      next_no_q   <= START_V;
      valid_q     <= 1'b0;
      rej_q       <= 1'b0;
      waiting_q   <= '0;
      take_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ticket_no_q <= ticket_no_d;
      next_no_q   <= next_no_d;
      valid_q     <= valid_d;
      rej_q       <= rej_d;
      waiting_q   <= waiting_d;
      take_q      <= bus.take_btn;
    end
  end

  assign bus.ticket_no    = ticket_no_q;
  assign bus.ticket_valid = valid_q;
  assign bus.rejected     = rej_q;
  assign bus.waiting      = waiting_q;
  assign bus.full         = full;
  assign state_dbg_o      = state_q;

endmodule
